// File: rtl/prog_moore_fsm.sv
// Programmable Moore state machine: the next-state function and the per-state
// output are held in writable tables, so the FSM behaviour is loaded at run time.
// Both tables and the state register clear on reset; table writes are
// registered, so a same-cycle advance always reads the pre-write contents.
module prog_moore_fsm #(
    parameter int p_nstates   = 4,
    parameter int p_nbits_in  = 2,
    parameter int p_nbits_out = 1,
    localparam int SW = $clog2(p_nstates),
    localparam int AW = SW + p_nbits_in,
    localparam int DW = (SW > p_nbits_out) ? SW : p_nbits_out
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [p_nbits_in-1:0]  in_,
    input  logic                   cfg_en,
    input  logic                   cfg_sel,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [DW-1:0]          cfg_data,
    output logic [SW-1:0]          state,
    output logic [p_nbits_out-1:0] out
);

    localparam int NT = p_nstates << p_nbits_in;

    logic [SW-1:0]          trans_tbl [NT];
    logic [p_nbits_out-1:0] out_tbl   [p_nstates];
    logic [SW-1:0]          state_next;

    // Next state: table lookup on {state, symbol} when enabled, otherwise hold.
    always_comb begin
        state_next = state;
        if (en) begin
            state_next = trans_tbl[{state, in_}];
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '0;
        end else begin
            state <= state_next;
        end
    end

    // Table storage: cleared on reset, otherwise one entry written per cfg strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            trans_tbl <= '{default: '0};
            out_tbl   <= '{default: '0};
        end else if (cfg_en) begin
            if (cfg_sel) begin
                out_tbl[cfg_addr[SW-1:0]] <= cfg_data[p_nbits_out-1:0];
            end else begin
                trans_tbl[cfg_addr] <= cfg_data[SW-1:0];
            end
        end
    end

    // Moore output: a function of the registered state only.
    always_comb begin
        out = out_tbl[state];
    end

endmodule

// File: doc/prog_moore_fsm.md
PROG_MOORE_FSM -- requirements
Module: prog_moore_fsm

Interface
REQ-001 Parameter p_nstates, default 4: number of states; SHALL be a power of two, 2 to 256; SW = $clog2(p_nstates).
REQ-002 Parameter p_nbits_in, default 2: input symbol width; legal range 1 to 4.
REQ-003 Parameter p_nbits_out, default 1: Moore output width; legal range 1 to 8.
REQ-004 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- en  in  1  advance enable; state updates only when high.
- in_  in  p_nbits_in  current input symbol.
- cfg_en  in  1  table write strobe.
- cfg_sel  in  1  write target: 0 = transition table, 1 = output table.
- cfg_addr  in  SW+p_nbits_in  transition index {state,symbol}; output writes use the low SW bits only.
- cfg_data  in  max(SW,p_nbits_out)  write data; low SW bits for transition writes, low p_nbits_out bits for output writes.
- state  out  SW  current state register.
- out  out  p_nbits_out  Moore output of the current state.

Function
REQ-006 The block SHALL hold a transition table of p_nstates*2^p_nbits_in entries, each SW bits wide, indexed {state,in_}.
REQ-007 The block SHALL hold an output table of p_nstates entries, each p_nbits_out bits wide, indexed by state.
REQ-008 On a rising clk with en=1 and reset=0, state SHALL load trans_tbl[{state,in_}]; with en=0, state SHALL hold.
REQ-009 out SHALL equal out_tbl[state] combinationally; it SHALL depend only on state and table contents, never on in_ (Moore).
REQ-010 When cfg_en=1 and reset=0, the addressed entry SHALL be written at the rising clk; the new value SHALL be visible the following cycle.
REQ-011 A write and an advance in the same cycle: the advance SHALL use the pre-write table contents, including when the write hits the entry being read.
REQ-012 A write to the output entry of the current state SHALL change out one cycle after the write edge; there SHALL be no same-cycle bypass.
REQ-013 On a transition-table write, cfg_data bits above SW SHALL be ignored.
REQ-014 On an output-table write, cfg_addr bits above SW and cfg_data bits above p_nbits_out SHALL be ignored.
REQ-015 cfg_en=0 SHALL leave both tables unchanged regardless of cfg_sel, cfg_addr and cfg_data.
REQ-016 Every index is in range (p_nstates is a power of two), so no illegal state SHALL be reachable.

Reset
REQ-017 When reset=1 at a rising clk: state SHALL be 0, every transition entry SHALL be 0, and every output entry SHALL be 0; out therefore reads 0.
REQ-018 Reset SHALL take priority over cfg_en and en in the same cycle.
REQ-019 Reset asserted mid-sequence SHALL discard all programmed contents; reprogramming is required afterwards.

Verification
REQ-020 Reset with en=1, in_=3 for 3 cycles, then release -> state=0, out=0 every cycle, both before and after release.
REQ-021 Defaults: program the 4-state table (A=0,B=1,C=2,D=3):
- next states for in_=00/01/10/11: A: A,B,A,D; B: C,B,A,D; C: A,D,A,D; D: C,B,A,D.
- outputs: D=1, others 0.
- Stimulus: from A with en=1, apply in_ = 01,00,01,11,00.
- Required: states A,B,C,D,D,C; out 0,0,0,1,1,0.
REQ-022 Hold: same table, en=0 with in_ toggling for 4 cycles -> state and out unchanged.
REQ-023 Collision: in state B with in_=00, write trans[{B,00}]=D with en=1 in the same cycle -> next state C; re-entering B with in_=00 later -> D.
REQ-024 Output update: in state C, write out_tbl[C]=1 -> out=0 in the write cycle, out=1 the next cycle.
REQ-025 Parameter sweep: run p_nstates=16, p_nbits_in=3, p_nbits_out=4 with a random table; compare against a cycle model over 1000 random cycles with random en, cfg_en and reset.
